mc_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the MIPS core. It replaces the single-cycle control unit when the datapath is rebuilt around a shared memory, an instruction register, A/B/ALUOut/data registers and a single ALU. Each instruction is stepped through FETCH/DECODE/execute/writeback states. The block drives every datapath mux select and write enable, one state per clock.

---
 rtl/mc_ctrl_fsm_if.sv | 37 +++
 rtl/mc_ctrl_fsm.sv | 184 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
//   en, opcode, funct, zero : status/enable inputs to the sequencer
//   pc_we .. pc_src          : datapath write enables and mux selects
//   illegal                  : one-cycle pulse for an unsupported encoding
//   state                    : current sequencer state (debug)
// master = sequencer side, slave = datapath side.
interface mc_ctrl_fsm_if;
    logic       en;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we;
    logic       iord;
    logic       we_dm;
    logic       ir_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       we_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  en, opcode, funct, zero,
        output pc_we, iord, we_dm, ir_we, reg_dst, wd_sel, we_reg,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, state
    );

    modport slave (
        output en, opcode, funct, zero,
        input  pc_we, iord, we_dm, ir_we, reg_dst, wd_sel, we_reg,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer. Steps each instruction through
// FETCH/DECODE/execute/writeback, one state per clock, and drives every
// datapath mux select and write enable as a Moore decode of the state.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset (0 = reset)
//   bus : mc_ctrl_fsm_if.master (en/opcode/funct/zero in, controls out)
// SUPPORT_JR_JAL = 0 decodes the JR funct and JAL opcode as illegal.
module mc_ctrl_fsm #(
    parameter bit SUPPORT_JR_JAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXEC = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        JR     = 4'd12, JAL    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       pc_write, branch, we_dm_raw, ir_we_raw, we_reg_raw, illegal_raw;
    logic       iord, alu_src_a;
    logic [1:0] reg_dst, wd_sel, alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       wr_ok;

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= FETCH;
        else if (bus.en)
            state_q <= state_d;
    end

    always_comb begin
        state_d     = FETCH;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        we_dm_raw   = 1'b0;
        ir_we_raw   = 1'b0;
        reg_dst     = '0;
        wd_sel      = '0;
        we_reg_raw  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = '0;
        alu_ctrl    = ALU_ADD;
        pc_src      = '0;
        illegal_raw = 1'b0;
        case (state_q)
            FETCH: begin
                ir_we_raw = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                // ALU precomputes PC+4 + (sext imm << 2) for a possible branch
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE: begin
                        case (bus.funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_d = RTEXEC;
                            FN_JR: begin
                                if (SUPPORT_JR_JAL) state_d = JR;
                                else                illegal_raw = 1'b1;
                            end
                            default: illegal_raw = 1'b1;
                        endcase
                    end
                    OP_BEQ:  state_d = BRANCH;
                    OP_ADDI: state_d = ADDIEX;
                    OP_J:    state_d = JUMP;
                    OP_JAL: begin
                        if (SUPPORT_JR_JAL) state_d = JAL;
                        else                illegal_raw = 1'b1;
                    end
                    default: illegal_raw = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                wd_sel     = 2'b01;
                we_reg_raw = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                we_dm_raw = 1'b1;
            end
            RTEXEC: begin
                alu_src_a = 1'b1;
                case (bus.funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 2'b01;
                we_reg_raw = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: we_reg_raw = 1'b1;
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            JR: begin
                pc_src   = 2'b11;
                pc_write = 1'b1;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                reg_dst    = 2'b10;
                wd_sel     = 2'b10;
                we_reg_raw = 1'b1;
                pc_src     = 2'b10;
                pc_write   = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // A reset cycle or a stalled cycle must not commit any architectural write.
    assign wr_ok = bus.en & rst;

    assign bus.pc_we     = wr_ok & (pc_write | (branch & bus.zero));
    assign bus.we_dm     = wr_ok & we_dm_raw;
    assign bus.ir_we     = wr_ok & ir_we_raw;
    assign bus.we_reg    = wr_ok & we_reg_raw;
    assign bus.illegal   = wr_ok & illegal_raw;
    assign bus.iord      = iord;
    assign bus.reg_dst   = reg_dst;
    assign bus.wd_sel    = wd_sel;
    assign bus.alu_src_a = alu_src_a;
    assign bus.alu_src_b = alu_src_b;
    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.pc_src    = pc_src;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: drives two instances (SUPPORT_JR_JAL = 1 and 0)
// with identical directed inputs. Each cycle the stimulus pushes the
// hand-derived expected control word for both instances into a queue; a
// monitor pops one entry per cycle on the falling edge and compares.
module tb_mc_ctrl_fsm;
    typedef struct packed {
        logic       pc_we;
        logic       iord;
        logic       we_dm;
        logic       ir_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       we_reg;
        logic       a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [1:0] pc_src;
        logic       ill;
        logic [3:0] st;
    } ctl_t;

    typedef struct {
        ctl_t e1;
        ctl_t e0;
        int   idx;
    } ent_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       zero;
    logic [5:0] opcode;
    logic [5:0] funct;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   vec_idx = 0;

    mc_ctrl_fsm_if if1 ();
    mc_ctrl_fsm_if if0 ();

    assign if1.en = en;  assign if1.zero = zero;  assign if1.opcode = opcode;  assign if1.funct = funct;
    assign if0.en = en;  assign if0.zero = zero;  assign if0.opcode = opcode;  assign if0.funct = funct;

    mc_ctrl_fsm #(.SUPPORT_JR_JAL(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
    mc_ctrl_fsm #(.SUPPORT_JR_JAL(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));

    ctl_t act1, act0;
    assign act1 = {if1.pc_we, if1.iord, if1.we_dm, if1.ir_we, if1.reg_dst, if1.wd_sel, if1.we_reg,
                   if1.alu_src_a, if1.alu_src_b, if1.alu_ctrl, if1.pc_src, if1.illegal, if1.state};
    assign act0 = {if0.pc_we, if0.iord, if0.we_dm, if0.ir_we, if0.reg_dst, if0.wd_sel, if0.we_reg,
                   if0.alu_src_a, if0.alu_src_b, if0.alu_ctrl, if0.pc_src, if0.illegal, if0.state};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control word per state with en = 1, rst = 1, zero = 0,
    // no illegal decode and the add encoding in RTEXEC.
    function automatic ctl_t ex(input logic [3:0] s);
        ctl_t c;
        c     = '0;
        c.alu = 3'b010;
        c.st  = s;
        case (s)
            4'd0:  begin c.ir_we = 1'b1; c.b = 2'b01; c.pc_we = 1'b1; end
            4'd1:  c.b = 2'b11;
            4'd2:  begin c.a = 1'b1; c.b = 2'b10; end
            4'd3:  c.iord = 1'b1;
            4'd4:  begin c.wd_sel = 2'b01; c.we_reg = 1'b1; end
            4'd5:  begin c.iord = 1'b1; c.we_dm = 1'b1; end
            4'd6:  c.a = 1'b1;
            4'd7:  begin c.reg_dst = 2'b01; c.we_reg = 1'b1; end
            4'd8:  begin c.a = 1'b1; c.alu = 3'b110; c.pc_src = 2'b01; end
            4'd9:  begin c.a = 1'b1; c.b = 2'b10; end
            4'd10: c.we_reg = 1'b1;
            4'd11: begin c.pc_src = 2'b10; c.pc_we = 1'b1; end
            4'd12: begin c.pc_src = 2'b11; c.pc_we = 1'b1; end
            4'd13: begin c.reg_dst = 2'b10; c.wd_sel = 2'b10; c.we_reg = 1'b1;
                         c.pc_src = 2'b10; c.pc_we = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t gated(input ctl_t c);
        c.pc_we  = 1'b0;
        c.we_dm  = 1'b0;
        c.ir_we  = 1'b0;
        c.we_reg = 1'b0;
        c.ill    = 1'b0;
        return c;
    endfunction

    function automatic ctl_t w_alu(input ctl_t c, input logic [2:0] alu);
        c.alu = alu;
        return c;
    endfunction

    function automatic ctl_t w_pcwe(input ctl_t c);
        c.pc_we = 1'b1;
        return c;
    endfunction

    function automatic ctl_t w_ill(input ctl_t c);
        c.ill = 1'b1;
        return c;
    endfunction

    task automatic cyc2(input ctl_t e1, input ctl_t e0);
        ent_t t;
        t.e1  = e1;
        t.e0  = e0;
        t.idx = vec_idx;
        vec_idx++;
        q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input ctl_t e);
        cyc2(e, e);
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    initial begin
        ent_t t;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                t = q.pop_front();
                n_vec++;
                if (act1 !== t.e1) begin
                    n_err++;
                    $display("FAIL vec%0d jrjal1 ctl: got %h required %h", t.idx, act1, t.e1);
                end
                n_vec++;
                if (act0 !== t.e0) begin
                    n_err++;
                    $display("FAIL vec%0d jrjal0 ctl: got %h required %h", t.idx, act0, t.e0);
                end
            end
        end
    end

    initial begin
        rst  = 1'b0;
        en   = 1'b1;
        zero = 1'b0;
        instr(6'b100011, 6'b000000);
        @(posedge clk);
        #1;
        // Reset held: FETCH with every write enable suppressed
        cyc(gated(ex(4'd0)));
        rst = 1'b1;

        // lw: 5 cycles
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(ex(4'd2)); cyc(ex(4'd3)); cyc(ex(4'd4));

        // R-type sub, slt, and
        instr(6'b000000, 6'b100010);
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(w_alu(ex(4'd6), 3'b110)); cyc(ex(4'd7));
        instr(6'b000000, 6'b101010);
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(w_alu(ex(4'd6), 3'b111)); cyc(ex(4'd7));
        instr(6'b000000, 6'b100100);
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(w_alu(ex(4'd6), 3'b000)); cyc(ex(4'd7));

        // beq taken, then not taken
        instr(6'b000100, 6'b000000);
        zero = 1'b1;
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(w_pcwe(ex(4'd8)));
        zero = 1'b0;
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(ex(4'd8));

        // addi, j
        instr(6'b001000, 6'b000000);
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(ex(4'd9)); cyc(ex(4'd10));
        instr(6'b000010, 6'b000000);
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(ex(4'd11));

        // Illegal opcode and illegal R-type funct retire in 2 cycles
        instr(6'b111111, 6'b000000);
        cyc(ex(4'd0)); cyc(w_ill(ex(4'd1)));
        instr(6'b000000, 6'b000000);
        cyc(ex(4'd0)); cyc(w_ill(ex(4'd1)));

        // sw with a 3-cycle stall in MEMWR
        instr(6'b101011, 6'b000000);
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(ex(4'd2));
        en = 1'b0;
        cyc(gated(ex(4'd5))); cyc(gated(ex(4'd5))); cyc(gated(ex(4'd5)));
        en = 1'b1;
        cyc(ex(4'd5));

        // lw aborted by reset in MEMRD
        instr(6'b100011, 6'b000000);
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(ex(4'd2));
        rst = 1'b0;
        cyc(gated(ex(4'd3)));
        rst = 1'b1;

        // lw aborted by reset in MEMWB: RF write suppressed
        cyc(ex(4'd0)); cyc(ex(4'd1)); cyc(ex(4'd2)); cyc(ex(4'd3));
        rst = 1'b0;
        cyc(gated(ex(4'd4)));
        rst = 1'b1;

        // jal: supported on dut1, illegal on dut0; reset re-aligns the two
        instr(6'b000011, 6'b000000);
        cyc(ex(4'd0));
        cyc2(ex(4'd1), w_ill(ex(4'd1)));
        cyc2(ex(4'd13), ex(4'd0));
        rst = 1'b0;
        cyc2(gated(ex(4'd0)), gated(ex(4'd1)));
        rst = 1'b1;

        // jr: same pattern
        instr(6'b000000, 6'b001000);
        cyc(ex(4'd0));
        cyc2(ex(4'd1), w_ill(ex(4'd1)));
        cyc2(ex(4'd12), ex(4'd0));
        rst = 1'b0;
        cyc2(gated(ex(4'd0)), gated(ex(4'd1)));
        rst = 1'b1;
        instr(6'b100011, 6'b000000);
        cyc(ex(4'd0));

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
